// File: rtl/qspi_fetch_buffer_pkg.sv
// Shared definitions for the QSPI instruction prefetch buffer.
package qspi_fetch_buffer_pkg;

  localparam int HALFWORD_BITS = 16;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STOP   = 2'd1;
  localparam logic [1:0] ST_START  = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  // Flash words arrive big-endian; the CPU wants little-endian halfwords.
  function automatic logic [HALFWORD_BITS-1:0] bswap16(input logic [HALFWORD_BITS-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/qspi_fetch_buffer_fifo.sv
// Synchronous halfword FIFO with flush; count is registered so the
// head becomes visible one cycle after the push edge.
module prefetch_fifo
  import qspi_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = HALFWORD_BITS,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Storage array; contents are don't-care until counted valid
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;

  // Pointers and occupancy; pointers wrap modulo DEPTH (not necessarily a power of two)
  always_ff @(posedge clk)
    if (!rstn || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop) rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (push_i && !do_pop)      count_q <= count_q + 1'b1;
      else if (!push_i && do_pop) count_q <= count_q - 1'b1;
    end

endmodule

// File: rtl/qspi_fetch_buffer.sv
// Instruction prefetch buffer: restarts the flash read on a redirect,
// streams halfwords into a small FIFO and throttles the controller.
module qspi_fetch_buffer
  import qspi_fetch_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     fetch_restart,
  input  logic [ADDR_BITS-1:0]     fetch_addr,
  output logic [HALFWORD_BITS-1:0] instr_data,
  output logic [ADDR_BITS-1:0]     instr_addr,
  output logic                     instr_valid,
  input  logic                     instr_pop,
  output logic [ADDR_BITS-1:0]     flash_addr,
  output logic                     flash_start_read,
  output logic                     flash_stall_read,
  output logic                     flash_stop_read,
  input  logic [HALFWORD_BITS-1:0] flash_data,
  input  logic                     flash_data_ready,
  input  logic                     flash_busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]           state_q, state_d;
  logic                 stop_q, start_q, taken_q;
  logic [ADDR_BITS-1:0] flash_addr_q, head_addr_q, fetch_ptr_q;
  logic [ADDR_BITS-1:0] restart_addr;
  logic [CW-1:0]        fifo_count;
  logic                 push, pop;

  assign restart_addr = fetch_addr & ~ADDR_BITS'(1);

  // A restart in the same cycle discards both push and pop.
  assign push = (state_q == ST_STREAM) && flash_data_ready && !taken_q && !fetch_restart;
  assign pop  = instr_pop && instr_valid && !fetch_restart;

  assign instr_valid      = (fifo_count != '0);
  assign instr_addr       = head_addr_q;
  assign flash_addr       = flash_addr_q;
  assign flash_start_read = start_q;
  assign flash_stop_read  = stop_q;
  // One word may still be in flight when stall rises, hence DEPTH-1.
  assign flash_stall_read = (state_q == ST_STREAM) && (fifo_count >= CW'(DEPTH - 1));

  prefetch_fifo #(.DEPTH(DEPTH), .W(HALFWORD_BITS), .CW(CW)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (fetch_restart),
    .push_i  (push),
    .wdata_i (bswap16(flash_data)),
    .pop_i   (pop),
    .rdata_o (instr_data),
    .count_o (fifo_count)
  );

  // Next-state: any restart aborts to STOP, then START, then STREAM
  always_comb begin
    state_d = state_q;
    if (fetch_restart) state_d = ST_STOP;
    else begin
      case (state_q)
        ST_STOP:  state_d = ST_START;
        ST_START: state_d = ST_STREAM;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM, controller pulses, address tracking and held-word guard
  always_ff @(posedge clk)
    if (!rstn) begin
      state_q      <= ST_IDLE;
      stop_q       <= 1'b0;
      start_q      <= 1'b0;
      taken_q      <= 1'b0;
      flash_addr_q <= '0;
      head_addr_q  <= '0;
      fetch_ptr_q  <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= fetch_restart;
      start_q <= (state_q == ST_STOP) && !fetch_restart;
      if ((state_q == ST_STOP) && !fetch_restart) flash_addr_q <= fetch_ptr_q;
      if (fetch_restart) begin
        head_addr_q <= restart_addr;
        fetch_ptr_q <= restart_addr;
      end else if (pop) begin
        head_addr_q <= head_addr_q + ADDR_BITS'(2);
      end
      // A stalled controller holds ready high on the same word; push it once.
      if (push)                   taken_q <= 1'b1;
      else if (!flash_data_ready) taken_q <= 1'b0;
    end

  // Flow-control sanity: never push into a full FIFO, only accept words from a busy controller
  always_ff @(posedge clk)
    if (rstn && push) begin
      assert (fifo_count != CW'(DEPTH));
      assert (flash_busy);
    end

endmodule
